mul_share_arbiter: RTL

Round-robin arbiter that shares one pipelined signed multiplier (27-bit x 30-bit, 30-bit truncated product) between `N_REQ` requesters in the Y-arbitration stage of the SpMV datapath. Each requester offers operands plus a tag over a valid/ready handshake. Results return in issue order with the winner's ID and tag through a small credit-protected result FIFO. The multiplier never stalls: backpressure is absorbed by withholding grants rather than by gating the pipeline.

---
 rtl/mul_arb_pkg.sv | 35 +++
 rtl/mul_pipe_27x30s.sv | 36 +++
 rtl/mul_share_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// Shared widths, the FIFO entry type and the round-robin pick function for
// mul_share_arbiter and its multiplier sub-block.
package mul_arb_pkg;

  localparam int A_W       = 27;
  localparam int B_W       = 30;
  localparam int P_W       = 30;
  localparam int N_MAX     = 8;
  localparam int ID_MAX_W  = 3;
  localparam int TAG_MAX_W = 32;

  // Sized for the largest legal configuration; narrower ids/tags are zero-extended.
  typedef struct packed {
    logic [P_W-1:0]       prod;
    logic [ID_MAX_W-1:0]  id;
    logic [TAG_MAX_W-1:0] tag;
  } mul_res_t;

  // First set bit of mask searching upward from ptr+1, modulo n.
  function automatic logic [ID_MAX_W-1:0] rr_pick(input logic [N_MAX-1:0]    mask,
                                                  input logic [ID_MAX_W-1:0] ptr,
                                                  input int                  n);
    logic [ID_MAX_W-1:0] win;
    int                  idx;
    win = '0;
    for (int k = N_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (mask[ID_MAX_W'(idx)]) win = ID_MAX_W'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mul_pipe_27x30s.sv
// Two-stage signed 27x30 multiplier (operand and product registers), product
// truncated to 30 bits; standalone so the DSP mapping can be swapped.
module mul_pipe_27x30s
  import mul_arb_pkg::*;
(
  input  logic           clk,
  input  logic           i_ce,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic [P_W-1:0] o_p
);

  logic [A_W-1:0] r_a;
  logic [B_W-1:0] r_b;
  logic [P_W-1:0] r_p;
  logic [P_W-1:0] w_a_ext;

  // The low P_W product bits depend only on the low P_W operand bits, so
  // sign-extending a to P_W and multiplying at P_W gives the wrapped result.
  assign w_a_ext = {{(P_W-A_W){r_a[A_W-1]}}, r_a};

  // NOTE: non-blocking assignments make r_p use the operands captured on the
  // previous edge, giving a true two-stage pipeline.
  // NOTE: data registers carry no reset; the valid bits travelling alongside
  // decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      r_a <= i_a;
      r_b <= i_b;
      r_p <= w_a_ext * r_b;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier with a credit-protected
// in-order result FIFO. Define MUL_ARB_PERF_EN for per-requester grant/stall counters.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_W     = 16,
  parameter int RES_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*A_W-1:0]       req_a,
  input  logic [N_REQ*B_W-1:0]       req_b,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [P_W-1:0]             out_prod,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic [TAG_W-1:0]           out_tag
`ifdef MUL_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0]        perf_grant,
  output logic [N_REQ*32-1:0]        perf_stall
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_win;
  logic [CNT_W-1:0] w_used;
  logic             w_can_issue;
  logic             w_accept;
  logic [A_W-1:0]   w_a;
  logic [B_W-1:0]   w_b;
  logic [P_W-1:0]   w_prod;

  logic             r_v1, r_v2;
  logic [ID_W-1:0]  r_id1, r_id2;
  logic [TAG_W-1:0] r_tag1, r_tag2;

  mul_res_t         r_mem [RES_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push, w_pop;
  mul_res_t         w_entry, w_head;
  logic             w_unused;

  // Every accepted request holds a credit until its result is popped.
  assign w_used      = CNT_W'(r_v1) + CNT_W'(r_v2) + CNT_W'(r_count);
  assign w_can_issue = w_used < CNT_W'(RES_DEPTH);
  assign w_win       = ID_W'(rr_pick(N_MAX'(req_valid), ID_MAX_W'(r_rr_ptr), N_REQ));

  // NOTE: req_ready gets a default before the conditional write so no latch is inferred.
  always_comb begin
    req_ready = '0;
    if (reset_n && w_can_issue && (|req_valid)) req_ready[w_win] = 1'b1;
  end

  assign w_accept = |(req_valid & req_ready);
  assign w_a      = req_a[int'(w_win)*A_W +: A_W];
  assign w_b      = req_b[int'(w_win)*B_W +: B_W];

  mul_pipe_27x30s u_mul (
    .clk  (clk),
    .i_ce (1'b1),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_p  (w_prod)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_rr_ptr <= ID_W'(N_REQ-1);
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      if (w_accept) r_rr_ptr <= w_win;
    end
  end

  always_ff @(posedge clk) begin
    r_id1  <= w_win;
    r_tag1 <= req_tag[int'(w_win)*TAG_W +: TAG_W];
    r_id2  <= r_id1;
    r_tag2 <= r_tag1;
  end

  assign w_push    = r_v2;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_entry      = '0;
    w_entry.prod = w_prod;
    w_entry.id   = ID_MAX_W'(r_id2);
    w_entry.tag  = TAG_MAX_W'(r_tag2);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign w_head   = r_mem[r_rd_ptr];
  assign out_prod = out_valid ? w_head.prod : '0;
  assign out_id   = out_valid ? ID_W'(w_head.id) : '0;
  assign out_tag  = out_valid ? TAG_W'(w_head.tag) : '0;
  assign w_unused = ^w_head;

`ifdef MUL_ARB_PERF_EN
  logic [31:0] r_grant_cnt [N_REQ];
  logic [31:0] r_stall_cnt [N_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_grant_cnt[i] <= '0;
        r_stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] &&  req_ready[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        if (req_valid[i] && !req_ready[i]) r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    assign perf_grant[g*32 +: 32] = r_grant_cnt[g];
    assign perf_stall[g*32 +: 32] = r_stall_cnt[g];
  end
`else
  // Counter build option off: no counters and no counter ports.
`endif

endmodule
